// File: rtl/status_init_ctrl.sv
// Status-array request front end: sweeps every status row to zero after reset, then
// forwards upstream requests through one registered stage. Optional re-sweep via STATUS_INIT_FLUSH_EN.
module status_init_ctrl #(
  parameter int TAG_WIDTH  = 1,
  parameter int ADDR_WIDTH = 4,
  parameter int ROW_WIDTH  = 8,
  parameter int NUM_BLOCKS = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [TAG_WIDTH-1:0]  i_tag,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ROW_WIDTH-1:0]  i_data,
  input  logic                  i_wen,
  input  logic [NUM_BLOCKS-1:0] i_wmask,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_ready,
`ifdef STATUS_INIT_FLUSH_EN
  input  logic                  i_flush,
`endif
  output logic [TAG_WIDTH-1:0]  o_tag,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ROW_WIDTH-1:0]  o_data,
  output logic                  o_wen,
  output logic [NUM_BLOCKS-1:0] o_wmask,
  output logic                  o_valid,
  output logic                  o_init_done
);

  typedef enum logic {SWEEP, PASS} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [TAG_WIDTH-1:0]  r_tag, w_tag_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [ROW_WIDTH-1:0]  r_data, w_data_nxt;
  logic                  r_wen, w_wen_nxt;
  logic [NUM_BLOCKS-1:0] r_wmask, w_wmask_nxt;
  logic                  r_valid, w_valid_nxt;
  logic                  r_init_done, w_init_done_nxt;
  logic                  w_flush;

`ifdef STATUS_INIT_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_tag_nxt       = r_tag;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_wen_nxt       = r_wen;
    w_wmask_nxt     = r_wmask;
    w_valid_nxt     = r_valid;
    w_init_done_nxt = r_init_done;
    if (i_ready) begin
      if (w_flush) begin
        // Flush edge issues nothing; the sweep restarts at row 0 on the next advancing edge.
        w_state_nxt = SWEEP;
        w_cnt_nxt   = '0;
        w_tag_nxt   = '0;
        w_addr_nxt  = '0;
        w_data_nxt  = '0;
        w_wen_nxt   = 1'b0;
        w_wmask_nxt = '0;
        w_valid_nxt = 1'b0;
      end else begin
        unique case (r_state)
          SWEEP: begin
            w_valid_nxt = 1'b1;
            w_wen_nxt   = 1'b1;
            w_addr_nxt  = r_cnt;
            w_data_nxt  = '0;
            w_wmask_nxt = '1;
            w_tag_nxt   = '0;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == '1) w_state_nxt = PASS;
          end
          PASS: begin
            w_valid_nxt = i_valid;
            w_wen_nxt   = i_wen;
            w_addr_nxt  = i_addr;
            w_tag_nxt   = i_valid ? i_tag   : '0;
            w_data_nxt  = i_valid ? i_data  : '0;
            w_wmask_nxt = i_valid ? i_wmask : '0;
          end
          default: w_state_nxt = SWEEP;
        endcase
      end
      w_init_done_nxt = (w_state_nxt == PASS);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state     <= SWEEP;
      r_cnt       <= '0;
      r_tag       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wen       <= 1'b0;
      r_wmask     <= '0;
      r_valid     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_tag       <= w_tag_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_wen       <= w_wen_nxt;
      r_wmask     <= w_wmask_nxt;
      r_valid     <= w_valid_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  assign o_ready     = i_ready & (r_state == PASS) & ~w_flush;
  assign o_tag       = r_tag;
  assign o_addr      = r_addr;
  assign o_data      = r_data;
  assign o_wen       = r_wen;
  assign o_wmask     = r_wmask;
  assign o_valid     = r_valid;
  assign o_init_done = r_init_done;

endmodule

// File: tb/tb_status_init_ctrl.sv
// Scoreboard bench for status_init_ctrl: a row-count reference model queues the expected
// output after every advancing edge; a negedge monitor pops and compares.
module tb_status_init_ctrl;

`ifdef STATUS_INIT_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [0:0] i_tag = '0;
  logic [3:0] i_addr = '0;
  logic [7:0] i_data = '0;
  logic       i_wen = 1'b0;
  logic [7:0] i_wmask = '0;
  logic       i_valid = 1'b0;
  logic       i_ready = 1'b1;
  logic       i_flush = 1'b0;
  logic       o_ready, o_wen, o_valid, o_init_done;
  logic [0:0] o_tag;
  logic [3:0] o_addr;
  logic [7:0] o_data, o_wmask;

  status_init_ctrl #(.TAG_WIDTH(1), .ADDR_WIDTH(4), .ROW_WIDTH(8), .NUM_BLOCKS(8)) dut (
    .clk(clk), .arst_n(arst_n),
    .i_tag(i_tag), .i_addr(i_addr), .i_data(i_data), .i_wen(i_wen), .i_wmask(i_wmask),
    .i_valid(i_valid), .o_ready(o_ready), .i_ready(i_ready),
`ifdef STATUS_INIT_FLUSH_EN
    .i_flush(i_flush),
`endif
    .o_tag(o_tag), .o_addr(o_addr), .o_data(o_data), .o_wen(o_wen), .o_wmask(o_wmask),
    .o_valid(o_valid), .o_init_done(o_init_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       wen;
    logic [0:0] tag;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] mask;
  } txn_t;

  txn_t        q[$];
  txn_t        held = '0;
  int unsigned rows_done = 0;   // rows written since the last reset/flush, saturating at 16
  bit          acc = 1'b0;      // request consumed on the most recent edge
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: 16 zeroing writes after reset or flush, then the accepted traffic.
  always @(posedge clk) begin
    txn_t t;
    acc = 1'b0;
    if (arst_n && i_ready) begin
      t = '0;
      if (FL && i_flush) begin
        rows_done = 0;
      end else if (rows_done < 16) begin
        t.v = 1'b1; t.wen = 1'b1; t.addr = 4'(rows_done); t.mask = 8'hFF;
        rows_done++;
      end else begin
        t.v = i_valid; t.wen = i_wen; t.addr = i_addr;
        if (i_valid) begin
          t.tag = i_tag; t.data = i_data; t.mask = i_wmask;
        end
        acc = i_valid;
      end
      q.push_back(t);
    end
  end

  always @(negedge clk) begin
    txn_t a;
    logic er;
    a  = {o_valid, o_wen, o_tag, o_addr, o_data, o_wmask};
    if (q.size() > 0) held = q.pop_front();
    chk("outputs", 64'(a), 64'(held));
    er = arst_n && i_ready && (rows_done == 16) && !(FL && i_flush);
    chk("o_ready", 64'(o_ready), 64'(er));
    chk("o_init_done", 64'(o_init_done), 64'(arst_n && rows_done == 16));
  end

  task automatic clear_model();
    q.delete();
    held = '0;
    rows_done = 0;
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
  endtask

  // Advance one cycle; a request stays on the bus until the model sees it consumed.
  task automatic cycle(input logic rdy, input int unsigned pvalid);
    if (!i_valid || acc) begin
      i_valid = ($urandom_range(99) < pvalid);
      i_tag   = 1'($urandom);
      i_addr  = 4'($urandom);
      i_data  = 8'($urandom);
      i_wen   = 1'($urandom);
      i_wmask = 8'($urandom);
    end
    i_ready = rdy;
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned n;

    // Plain sweep after reset, idle upstream.
    i_ready = 1'b1;
    do_reset();
    repeat (17) cycle(1'b1, 0);
    chk("init_after_sweep", 64'(o_init_done), 64'd1);
    chk("idle_valid", 64'(o_valid), 64'd0);

    // Alternating i_ready, with a request pending through the sweep.
    i_ready = 1'b0;
    do_reset();
    i_valid = 1'b1; i_tag = 1'b1; i_addr = 4'd9; i_data = 8'hA5; i_wen = 1'b1; i_wmask = 8'h3C;
    n = 0;
    while (o_init_done !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      i_ready = ~i_ready;
    end
    chk("sweep_len_toggled", 64'(n), 64'd32);
    repeat (4) cycle(1'b1, 0);

    // Directed read, then an idle cycle.
    i_valid = 1'b1; i_tag = 1'b1; i_addr = 4'd5; i_data = 8'h00; i_wen = 1'b0; i_wmask = 8'h00;
    i_ready = 1'b1;
    @(posedge clk); #1;
    chk("rd_valid", 64'(o_valid), 64'd1);
    chk("rd_wen", 64'(o_wen), 64'd0);
    chk("rd_addr", 64'(o_addr), 64'd5);
    chk("rd_tag", 64'(o_tag), 64'd1);
    i_valid = 1'b0; i_tag = 1'b1; i_data = 8'h77;
    @(posedge clk); #1;
    chk("idle_valid2", 64'(o_valid), 64'd0);
    chk("idle_tag", 64'(o_tag), 64'd0);
    chk("idle_data", 64'(o_data), 64'd0);

    // Asynchronous reset after row 7 of the sweep.
    do_reset();
    repeat (8) cycle(1'b1, 0);
    chk("row7_addr", 64'(o_addr), 64'd7);
    #2 arst_n = 1'b0;
    clear_model();
    #1;
    chk("areset_valid", 64'(o_valid), 64'd0);
    chk("areset_addr", 64'(o_addr), 64'd0);
    chk("areset_wmask", 64'(o_wmask), 64'd0);
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (3) cycle(1'b1, 0);
    chk("restart_addr", 64'(o_addr), 64'd2);

    // Randomized traffic with random back-pressure, sweep included.
    repeat (400) cycle(($urandom_range(99) < 75), 60);

`ifdef STATUS_INIT_FLUSH_EN
    repeat (20) cycle(1'b1, 0);
    i_valid = 1'b1; i_tag = 1'b0; i_addr = 4'd3; i_data = 8'h5A; i_wen = 1'b1; i_wmask = 8'h81;
    i_flush = 1'b1; i_ready = 1'b1;
    @(posedge clk); #1;
    chk("flush_not_acc", 64'(acc), 64'd0);
    chk("flush_init_low", 64'(o_init_done), 64'd0);
    i_flush = 1'b0;
    repeat (20) cycle(1'b1, 0);
    repeat (100) cycle(($urandom_range(99) < 75), 60);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/status_init_ctrl.md
# status_init_ctrl

Request-side front end of the status array. After reset it sweeps all 16 status rows, writing zero with a full write mask so every block starts invalid. Once the sweep completes it forwards lookup and fill requests to the status array through one registered stage. It sits directly upstream of the status array and drives that block's tag, address, data, write-enable, write-mask and valid inputs.

## Interface
Parameters:
- TAG_WIDTH, 1: width of the tag carried alongside each request.
- ADDR_WIDTH, 4: status row address width, from the shared parameter header (16 rows).
- ROW_WIDTH, 8: status row width, from the shared parameter header.
- NUM_BLOCKS, 8: write-mask width, one bit per block.

Ports:
- clk  in  1  clock; one clock domain.
- arst_n  in  1  reset, asynchronous, active-low.
- i_tag  in  TAG_WIDTH  upstream request tag.
- i_addr  in  ADDR_WIDTH  upstream row address.
- i_data  in  ROW_WIDTH  upstream write data.
- i_wen  in  1  1 = write, 0 = read.
- i_wmask  in  NUM_BLOCKS  upstream block write mask.
- i_valid  in  1  upstream request valid.
- o_ready  out  1  upstream may present a request; accepted on an edge where i_valid & o_ready.
- i_ready  in  1  status array ready (its o_ready, i.e. ~halt).
- o_tag, o_addr, o_data, o_wen, o_wmask  out  widths as above  request to the status array.
- o_valid  out  1  request valid to the status array.
- o_init_done  out  1  high while the array is initialized and pass-through is active.
- i_flush  in  1  re-sweep request; present only with STATUS_INIT_FLUSH_EN.

## Operation
- States: SWEEP, PASS. Reset enters SWEEP with a 4-bit row counter at 0.
- All registers advance only on edges where i_ready=1. When i_ready=0, the state, counter and every output register hold.
- SWEEP behaviour:
  - Each advancing edge registers o_valid=1, o_wen=1, o_addr=cnt, o_data=0, o_wmask=all ones, o_tag=0, then increments cnt.
  - On the edge that issues row 15, cnt wraps to 0 and the state becomes PASS.
- PASS behaviour:
  - Each advancing edge registers o_valid=i_valid and copies i_tag, i_addr, i_data, i_wen and i_wmask to the outputs.
  - When i_valid=0, o_tag, o_data and o_wmask register 0 so idle cycles carry zero payloads.
- o_ready = i_ready & (state==PASS) & ~flush_req. flush_req is 0 when the macro is off.
- o_init_done is registered and equals (state==PASS).
- A request presented while o_ready=0 is not consumed. Upstream holds it.

## Timing
- Reset values: o_valid=0, o_wen=0, o_tag=0, o_addr=0, o_data=0, o_wmask=0, o_init_done=0. o_ready=0 throughout reset (state is SWEEP).
- Sweep timing (first edge after arst_n rises is edge 1, with i_ready=1 throughout):
  - Row k is driven on the outputs after edge k+1, for k = 0..15.
  - o_init_done rises after edge 16. o_ready rises during the cycle after edge 16.
- Sweep duration is 16 advancing edges. Each i_ready=0 cycle extends it by one cycle.
- Pass-through latency: a request accepted on edge n is on the outputs after edge n and is held until the next advancing edge.
- Asserting arst_n mid-sweep or mid-pass clears everything asynchronously and restarts the sweep at row 0.

## Configuration
- STATUS_INIT_FLUSH_EN defined:
  - Adds the i_flush port.
  - i_flush=1 on an advancing edge in PASS: that edge loads SWEEP with cnt=0, and o_init_done falls after that edge. No upstream request is accepted on that edge (o_ready=0 while i_flush=1). The sweep then reissues rows 0..15 exactly as after reset.
  - i_flush=1 during SWEEP restarts the count at 0 on that edge.
- STATUS_INIT_FLUSH_EN undefined: there is no i_flush port, and a sweep happens only after reset.

## Test plan
- Reset release with i_ready=1 and i_valid=0 → 16 writes, addr 0..15, data 0x00, wmask 0xFF; o_init_done=1 after edge 16; o_valid=0 after edge 17.
- Toggle i_ready 0/1 every cycle during the sweep → each row is issued exactly once, in order, with the sweep taking 32 cycles; outputs hold during low cycles.
- In PASS, read request addr=5, tag=1 → after the accepting edge: o_valid=1, o_wen=0, o_addr=5, o_tag=1. A following i_valid=0 cycle gives o_valid=0 and o_tag=0.
- Request with i_valid=1 during the sweep → o_ready=0; the request is accepted only in the first PASS cycle and forwarded unchanged.
- Assert arst_n low after row 7 → outputs clear immediately; after release the sweep restarts at addr 0.
- With STATUS_INIT_FLUSH_EN: i_flush pulse in PASS together with i_valid=1 → request not accepted, o_init_done falls, rows 0..15 are rewritten with 0, then the held request is accepted.
